btn_pulse_conditioner: RTL and testbench

- Upstream input stage for the pulse adder. Conditions N raw shield pushbuttons into clean single-cycle press pulses.
- Per button: 2-FF synchroniser, counter-based debounce, press-edge pulse generation.
- Optional hold-to-auto-repeat: holding a button keeps adding 1/16/256/4096 at a fixed rate.
- Replaces the separate per-button debounce + edge-detect chain in the top level. pulse_out connects directly to the adder's button inputs.

---
 rtl/btn_pulse_conditioner_pkg.sv | 20 ++
 rtl/btn_pulse_conditioner_channel.sv | 110 +++++++++++
 rtl/btn_pulse_conditioner.sv | 45 ++++
 tb/tb_btn_pulse_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_conditioner_pkg.sv
// btn_pulse_conditioner_pkg: channel FSM encoding and timing helpers shared by the button conditioner.
package btn_pulse_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    function automatic int ms_to_ticks(int clk_hz, int ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int max3(int a, int b, int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/btn_pulse_conditioner_channel.sv
// btn_channel: one button -- 2-FF synchroniser, debounce FSM and saturating counter.
// Auto-repeat states exist only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pulse_conditioner_pkg::*;
#(
    parameter int DB_TICKS   = 10,
    parameter int HOLD_TICKS = 50,
    parameter int REP_TICKS  = 20,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level,
    output logic rpt
);

    localparam int CW = $clog2(max3(DB_TICKS, HOLD_TICKS, REP_TICKS));
    localparam logic REL = ACTIVE_LOW;
    localparam logic [CW-1:0] DB_END = CW'(DB_TICKS - 1);

    logic [1:0]    sync;
    logic          p;
    logic          pulse_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    state_t        state, state_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= {2{REL}};
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_nx;
            cnt   <= cnt_nx;
            pulse <= pulse_nx;
        end
    end

    assign p       = sync[1] ^ REL;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Release always wins over a coinciding hold/repeat expiry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_inc;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (p) state_nx = DB_PRESS;
            end
            DB_PRESS:
                if (!p) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_END) begin
                    state_nx = HELD;
                    pulse_nx = 1'b1;
                    cnt_nx   = '0;
                end
            HELD:
                if (!p) begin
                    state_nx = DB_RELEASE;
                    cnt_nx   = '0;
`ifdef BTN_AUTOREPEAT_EN
                end else if (cnt == CW'(HOLD_TICKS - 1)) begin
                    state_nx = REPEAT;
                    pulse_nx = 1'b1;
                    cnt_nx   = '0;
                end
            REPEAT:
                if (!p) begin
                    state_nx = DB_RELEASE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(REP_TICKS - 1)) begin
                    pulse_nx = 1'b1;
                    cnt_nx   = '0;
                end
`else
                end else begin
                    cnt_nx = '0;
                end
`endif
            DB_RELEASE:
                if (p) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_END) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign level = (state == HELD) || (state == REPEAT) || (state == DB_RELEASE);
`ifdef BTN_AUTOREPEAT_EN
    assign rpt = (state == REPEAT);
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: N independent debounced press-pulse channels feeding the pulse adder.
// Optional hold-to-repeat behaviour is compiled in with BTN_AUTOREPEAT_EN.
module btn_pulse_conditioner
    import btn_pulse_conditioner_pkg::*;
#(
    parameter int N_BTN            = 4,
    parameter int CLK_FREQ_HZ      = 12000000,
    parameter int DEBOUNCE_TIME_MS = 10,
    parameter int HOLD_TIME_MS     = 500,
    parameter int REPEAT_TIME_MS   = 100,
    parameter bit BTN_ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] pulse_out,
    output logic [N_BTN-1:0] level_out,
    output logic [N_BTN-1:0] repeat_out
);

    localparam int DB_TICKS   = ms_to_ticks(CLK_FREQ_HZ, DEBOUNCE_TIME_MS);
    localparam int HOLD_TICKS = ms_to_ticks(CLK_FREQ_HZ, HOLD_TIME_MS);
    localparam int REP_TICKS  = ms_to_ticks(CLK_FREQ_HZ, REPEAT_TIME_MS);

    if (N_BTN < 1 || DB_TICKS < 2 || HOLD_TICKS < 2 || REP_TICKS < 2) begin : g_bad_cfg
        $error("btn_pulse_conditioner: N_BTN must be >= 1 and every tick count >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_TICKS  (DB_TICKS),
            .HOLD_TICKS(HOLD_TICKS),
            .REP_TICKS (REP_TICKS),
            .ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_in[i]),
            .pulse(pulse_out[i]),
            .level(level_out[i]),
            .rpt  (repeat_out[i])
        );
    end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// tb_btn_pulse_conditioner: scoreboard bench; stimulus queues expected pulses and probes, a monitor checks them.
module tb_btn_pulse_conditioner;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } pulse_e_t;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] rep;
        string      name;
    } probe_e_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_in = 4'hF;
    logic [3:0] pulse_out, level_out, repeat_out;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int t0, rr;

    pulse_e_t pulse_q[$];
    probe_e_t probe_q[$];

    btn_pulse_conditioner #(
        .N_BTN           (4),
        .CLK_FREQ_HZ     (10000),
        .DEBOUNCE_TIME_MS(1),
        .HOLD_TIME_MS    (5),
        .REPEAT_TIME_MS  (2),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .pulse_out (pulse_out),
        .level_out (level_out),
        .repeat_out(repeat_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pulse_e_t e;
        probe_e_t p;
        if (pulse_out !== 4'b0000) begin
            n_vec++;
            if (pulse_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse_unexpected: cycle %0d got pulse_out=%b, required none", cyc, pulse_out);
            end else begin
                e = pulse_q.pop_front();
                if (e.cyc != cyc || e.val !== pulse_out) begin
                    n_bad++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", pulse_out, cyc, e.val, e.cyc);
                end
            end
        end
        while (probe_q.size() != 0 && probe_q[0].cyc == cyc) begin
            p = probe_q.pop_front();
            n_vec++;
            if (level_out !== p.lvl || repeat_out !== p.rep) begin
                n_bad++;
                $display("FAIL %s: cycle %0d got level=%b repeat=%b, required level=%b repeat=%b",
                         p.name, cyc, level_out, repeat_out, p.lvl, p.rep);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic probe(input int c, input logic [3:0] l, input logic [3:0] r, input string nm);
        probe_q.push_back('{cyc: c, lvl: l, rep: r, name: nm});
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] v);
        pulse_q.push_back('{cyc: c, val: v});
    endtask

    initial begin
        probe(2, 4'b0000, 4'b0000, "reset_state");
        tick(3);
        rst = 1'b1;
        tick(5);

        // clean press on channel 0
        t0 = cyc;
        expect_pulse(t0 + 13, 4'b0001);
        probe(t0 + 12, 4'b0000, 4'b0000, "press_level_before");
        probe(t0 + 13, 4'b0001, 4'b0000, "press_level_rise");
        probe(t0 + 25, 4'b0001, 4'b0000, "press_level_held");
        btn_in[0] = 1'b0;
        tick(30);
        rr = cyc;
        probe(rr + 12, 4'b0001, 4'b0000, "release_level_before");
        probe(rr + 13, 4'b0000, 4'b0000, "release_level_fall");
        btn_in[0] = 1'b1;
        tick(20);

        // bouncing channel 1 never qualifies
        t0 = cyc;
        probe(t0 + 8, 4'b0000, 4'b0000, "bounce_a");
        probe(t0 + 14, 4'b0000, 4'b0000, "bounce_b");
        probe(t0 + 20, 4'b0000, 4'b0000, "bounce_c");
        probe(t0 + 30, 4'b0000, 4'b0000, "bounce_d");
        btn_in[1] = 1'b0;
        tick(6);
        btn_in[1] = 1'b1;
        tick(3);
        btn_in[1] = 1'b0;
        tick(6);
        btn_in[1] = 1'b1;
        tick(20);

        // long hold on channel 2
        t0 = cyc;
        expect_pulse(t0 + 13, 4'b0100);
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(t0 + 63, 4'b0100);
        expect_pulse(t0 + 83, 4'b0100);
        expect_pulse(t0 + 103, 4'b0100);
        probe(t0 + 62, 4'b0100, 4'b0000, "hold_before_repeat");
        probe(t0 + 63, 4'b0100, 4'b0100, "repeat_enter");
        probe(t0 + 122, 4'b0100, 4'b0100, "repeat_last");
        probe(t0 + 123, 4'b0100, 4'b0000, "repeat_exit");
`else
        probe(t0 + 63, 4'b0100, 4'b0000, "hold_no_repeat_a");
        probe(t0 + 100, 4'b0100, 4'b0000, "hold_no_repeat_b");
`endif
        probe(t0 + 132, 4'b0100, 4'b0000, "hold_release_before");
        probe(t0 + 133, 4'b0000, 4'b0000, "hold_release_fall");
        btn_in[2] = 1'b0;
        tick(120);
        btn_in[2] = 1'b1;
        tick(25);

        // all channels at once
        t0 = cyc;
        expect_pulse(t0 + 13, 4'b1111);
        probe(t0 + 13, 4'b1111, 4'b0000, "simul_level");
        btn_in = 4'b0000;
        tick(20);
        rr = cyc;
        probe(rr + 14, 4'b0000, 4'b0000, "simul_release");
        btn_in = 4'b1111;
        tick(20);

        // async reset while channel 3 is held
        t0 = cyc;
        expect_pulse(t0 + 13, 4'b1000);
        probe(t0 + 39, 4'b1000, 4'b0000, "pre_reset_level");
        probe(t0 + 40, 4'b0000, 4'b0000, "async_reset_clear");
        btn_in[3] = 1'b0;
        tick(39);
        @(posedge clk);
        #2 rst = 1'b0;
        tick(3);
        rr = cyc;
        expect_pulse(rr + 13, 4'b1000);
        probe(rr + 12, 4'b0000, 4'b0000, "post_reset_before");
        probe(rr + 13, 4'b1000, 4'b0000, "post_reset_press");
        rst = 1'b1;
        tick(20);
        btn_in[3] = 1'b1;
        tick(20);

        while (pulse_q.size() != 0) begin
            pulse_e_t e;
            e = pulse_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL pulse_missing: got none, required %b at cycle %0d", e.val, e.cyc);
        end
        while (probe_q.size() != 0) begin
            probe_e_t p;
            p = probe_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: got unchecked probe, required check at cycle %0d", p.name, p.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
